csi_rx_pkt_parser: RTL and testbench

Parametrised CSI-2 packet parser for the camera front-end, placed between the word aligner and the RAW8/RAW10 unpacker in the `csi_byte_clk` domain. It generalises the single-channel depacketizer in four ways: lane count is a parameter (1/2/4), multiple virtual channels are tracked with per-VC frame/line flags, partial final beats carry a byte-enable, and header ECC checking can be compiled in. It consumes aligned lane bytes, walks each packet by its word count, and drives `sync_wait`/`packet_done` back to the aligners.

---
 rtl/csi_rx_pkt_parser.sv | 188 ++++++++++++++++++
 tb/tb_csi_rx_pkt_parser.sv | 276 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/csi_rx_pkt_parser.sv
`default_nettype none
// csi_rx_pkt_parser: CSI-2 packet walker with per-VC flags, byte-enabled payload beats.
// Optional header ECC check compiled in with CSI_ECC_CHECK_EN.  Rev 1.0
module csi_rx_pkt_parser #(
  parameter int NUM_LANE = 2,
  parameter int NUM_VC   = 2
) (
  input  logic                  clock,
  input  logic                  reset_n,
  input  logic                  enable,
  input  logic [NUM_LANE*8-1:0] data_in,
  input  logic                  data_vld,
  output logic                  sync_wait,
  output logic                  packet_done,
  output logic [NUM_LANE*8-1:0] payload,
  output logic [NUM_LANE-1:0]   payload_be,
  output logic                  payload_vld,
  output logic [1:0]            payload_vc,
  output logic [5:0]            payload_dt,
  output logic [NUM_VC-1:0]     frame_active,
  output logic [NUM_VC-1:0]     line_active,
  output logic                  hdr_err
);

  localparam int          HDR_BEATS = 4 / NUM_LANE;
  localparam logic [1:0]  HDR_LAST  = 2'(HDR_BEATS - 1);
  localparam logic [16:0] LANES     = 17'(NUM_LANE);

  typedef enum logic [1:0] {IDLE = 2'd0, HDR = 2'd1, BODY = 2'd2, DONE = 2'd3} state_t;

  state_t                state;
  logic [1:0]            hdr_cnt;
  logic [31:0]           hdr_q;
  logic [31:0]           hdr_now;
  logic [16:0]           remain;
  logic [16:0]           pay_left;
  logic [1:0]            cur_vc;
  logic [5:0]            cur_dt;
  logic                  cur_ok;
  logic                  payload_last;
  logic [NUM_LANE-1:0]   lane_be;
  logic [NUM_LANE*8-1:0] lane_data;
  logic                  hdr_last;
  logic                  ecc_bad;
  logic                  beat_last;
  logic [7:0]            di;
  logic [15:0]           wc;

  // Header bytes already captured merged with the bytes arriving on this beat.
  always_comb begin
    hdr_now = hdr_q;
    for (int k = 0; k < 4; k++) begin
      if (2'(k / NUM_LANE) == hdr_cnt)
        hdr_now[k*8 +: 8] = data_in[(k % NUM_LANE)*8 +: 8];
    end
  end

  assign di       = hdr_now[7:0];
  assign wc       = hdr_now[23:8];
  assign hdr_last = data_vld && (state == IDLE || state == HDR) && (hdr_cnt == HDR_LAST);

`ifdef CSI_ECC_CHECK_EN
  logic [5:0] ecc_calc;
  logic [1:0] unused_p76;
  assign ecc_calc = {^(hdr_now[23:0] & 24'hEFFC00), ^(hdr_now[23:0] & 24'hDF03F0),
                     ^(hdr_now[23:0] & 24'hB8E38E), ^(hdr_now[23:0] & 24'h749A6D),
                     ^(hdr_now[23:0] & 24'hF2555B), ^(hdr_now[23:0] & 24'hF12CB7)};
  assign ecc_bad    = (ecc_calc != hdr_now[29:24]);
  assign unused_p76 = hdr_now[31:30];
`else
  logic [7:0] unused_ecc;
  assign unused_ecc = hdr_now[31:24];
  assign ecc_bad    = 1'b0;
`endif

  // remain includes the two CRC bytes; payload bytes are whatever lies before them.
  assign pay_left  = (remain > 17'd2) ? (remain - 17'd2) : 17'd0;
  assign beat_last = (remain <= LANES);

  always_comb begin
    lane_be   = '0;
    lane_data = '0;
    for (int i = 0; i < NUM_LANE; i++) begin
      if (17'(i) < pay_left) begin
        lane_be[i]         = 1'b1;
        lane_data[i*8 +: 8] = data_in[i*8 +: 8];
      end
    end
  end

  always_ff @(posedge clock) begin
    if (!reset_n || !enable) begin
      state        <= IDLE;
      hdr_cnt      <= '0;
      hdr_q        <= '0;
      remain       <= '0;
      cur_vc       <= '0;
      cur_dt       <= '0;
      cur_ok       <= 1'b0;
      sync_wait    <= 1'b1;
      packet_done  <= 1'b0;
      payload      <= '0;
      payload_be   <= '0;
      payload_vld  <= 1'b0;
      payload_vc   <= '0;
      payload_dt   <= '0;
      payload_last <= 1'b0;
      frame_active <= '0;
      line_active  <= '0;
      hdr_err      <= 1'b0;
    end else begin
      packet_done  <= 1'b0;
      hdr_err      <= 1'b0;
      payload_vld  <= 1'b0;
      payload_be   <= '0;
      payload_last <= 1'b0;

      // The line ends once its final payload beat has been presented, or at packet end.
      for (int v = 0; v < NUM_VC; v++) begin
        if (cur_vc == 2'(v) && (state == DONE || (payload_vld && payload_last)))
          line_active[v] <= 1'b0;
      end

      case (state)
        IDLE, HDR: begin
          if (data_vld) begin
            if (hdr_last) begin
              hdr_cnt <= '0;
              cur_vc  <= di[7:6];
              cur_dt  <= di[5:0];
              cur_ok  <= ({1'b0, di[7:6]} < 3'(NUM_VC));
              if (ecc_bad || di[5:0] < 6'h10) begin
                state       <= DONE;
                packet_done <= 1'b1;
                sync_wait   <= 1'b1;
                hdr_err     <= ecc_bad;
                for (int v = 0; v < NUM_VC; v++) begin
                  if (!ecc_bad && di[7:6] == 2'(v)) begin
                    if (di[5:0] == 6'h00) begin
                      frame_active[v] <= 1'b1;
                    end else if (di[5:0] == 6'h01) begin
                      frame_active[v] <= 1'b0;
                      line_active[v]  <= 1'b0;
                    end
                  end
                end
              end else begin
                state     <= BODY;
                sync_wait <= 1'b0;
                remain    <= {1'b0, wc} + 17'd2;
                for (int v = 0; v < NUM_VC; v++) begin
                  if (di[7:6] == 2'(v))
                    line_active[v] <= 1'b1;
                end
              end
            end else begin
              hdr_q     <= hdr_now;
              hdr_cnt   <= hdr_cnt + 2'd1;
              state     <= HDR;
              sync_wait <= 1'b0;
            end
          end
        end
        BODY: begin
          if (data_vld) begin
            remain <= beat_last ? 17'd0 : (remain - LANES);
            if (cur_ok && pay_left != 17'd0) begin
              payload_vld  <= 1'b1;
              payload_be   <= lane_be;
              payload      <= lane_data;
              payload_vc   <= cur_vc;
              payload_dt   <= cur_dt;
              payload_last <= (pay_left <= LANES);
            end
            if (beat_last) begin
              state       <= DONE;
              packet_done <= 1'b1;
              sync_wait   <= 1'b1;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_csi_rx_pkt_parser.sv
`timescale 1ns/1ps
`default_nettype none
// tb_csi_rx_pkt_parser: directed table plus hand sequences over 4-, 2- and 1-lane instances.
module tb_csi_rx_pkt_parser;

  logic clock = 1'b0;
  always #5 clock = ~clock;

  logic reset_n, enable;

  // 4-lane instance
  logic [31:0] d4;  logic v4;
  logic s4, pd4, pv4, he4;  logic [31:0] pl4;  logic [3:0] be4;
  logic [1:0] vc4;  logic [5:0] dt4;  logic [1:0] fa4, la4;
  // 2-lane instance
  logic [15:0] d2;  logic v2;
  logic s2, pd2, pv2, he2;  logic [15:0] pl2;  logic [1:0] be2;
  logic [1:0] vc2;  logic [5:0] dt2;  logic [1:0] fa2, la2;
  // 1-lane instance
  logic [7:0] d1;  logic v1;
  logic s1, pd1, pv1, he1;  logic [7:0] pl1;  logic [0:0] be1;
  logic [1:0] vc1;  logic [5:0] dt1;  logic [1:0] fa1, la1;

  csi_rx_pkt_parser #(.NUM_LANE(4), .NUM_VC(2)) u4 (
    .clock(clock), .reset_n(reset_n), .enable(enable), .data_in(d4), .data_vld(v4),
    .sync_wait(s4), .packet_done(pd4), .payload(pl4), .payload_be(be4), .payload_vld(pv4),
    .payload_vc(vc4), .payload_dt(dt4), .frame_active(fa4), .line_active(la4), .hdr_err(he4));

  csi_rx_pkt_parser #(.NUM_LANE(2), .NUM_VC(2)) u2 (
    .clock(clock), .reset_n(reset_n), .enable(enable), .data_in(d2), .data_vld(v2),
    .sync_wait(s2), .packet_done(pd2), .payload(pl2), .payload_be(be2), .payload_vld(pv2),
    .payload_vc(vc2), .payload_dt(dt2), .frame_active(fa2), .line_active(la2), .hdr_err(he2));

  csi_rx_pkt_parser #(.NUM_LANE(1), .NUM_VC(2)) u1 (
    .clock(clock), .reset_n(reset_n), .enable(enable), .data_in(d1), .data_vld(v1),
    .sync_wait(s1), .packet_done(pd1), .payload(pl1), .payload_be(be1), .payload_vld(pv1),
    .payload_vc(vc1), .payload_dt(dt1), .frame_active(fa1), .line_active(la1), .hdr_err(he1));

  int errors = 0;
  int checks = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(negedge clock);
  endtask

  // Standard CSI-2 header ECC (P5..P0 parity masks over {WC, DI}).
  function automatic logic [31:0] hdr(input logic [7:0] di_b, input logic [15:0] wc_b);
    logic [23:0] d;
    logic [7:0]  e;
    d = {wc_b, di_b};
    e = {2'b00, ^(d & 24'hEFFC00), ^(d & 24'hDF03F0), ^(d & 24'hB8E38E),
         ^(d & 24'h749A6D), ^(d & 24'hF2555B), ^(d & 24'hF12CB7)};
    return {e, wc_b, di_b};
  endfunction

  typedef struct packed {
    logic        rstn;
    logic        vld;
    logic [31:0] d;
    logic        sync;
    logic        done;
    logic        pvld;
    logic [3:0]  be;
    logic [31:0] pl;
    logic [1:0]  fa;
    logic [1:0]  la;
  } vec_t;

  vec_t tbl [15];

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    logic [31:0] h;
    int          cnt_pv, early;
    logic [3:0]  last_be;

    reset_n = 1'b0; enable = 1'b1;
    d4 = '0; v4 = 1'b0; d2 = '0; v2 = 1'b0; d1 = '0; v1 = 1'b0;
    tick(); tick();

    //             rstn  vld  data                sync  done  pvld  be     payload       fa     la
    tbl[0]  = '{1'b0, 1'b0, 32'h0,             1'b1, 1'b0, 1'b0, 4'h0, 32'h0,        2'b00, 2'b00};
    tbl[1]  = '{1'b1, 1'b0, 32'h0,             1'b1, 1'b0, 1'b0, 4'h0, 32'h0,        2'b00, 2'b00};
    tbl[2]  = '{1'b1, 1'b1, hdr(8'h2B, 16'd6), 1'b0, 1'b0, 1'b0, 4'h0, 32'h0,        2'b00, 2'b01};
    tbl[3]  = '{1'b1, 1'b1, 32'h44332211,      1'b0, 1'b0, 1'b1, 4'hF, 32'h44332211, 2'b00, 2'b01};
    tbl[4]  = '{1'b1, 1'b0, 32'h0,             1'b0, 1'b0, 1'b0, 4'h0, 32'h0,        2'b00, 2'b01};
    tbl[5]  = '{1'b1, 1'b1, 32'hC2C16655,      1'b1, 1'b1, 1'b1, 4'h3, 32'h00006655, 2'b00, 2'b01};
    tbl[6]  = '{1'b1, 1'b0, 32'h0,             1'b1, 1'b0, 1'b0, 4'h0, 32'h0,        2'b00, 2'b00};
    tbl[7]  = '{1'b1, 1'b1, hdr(8'h00, 16'd0), 1'b1, 1'b1, 1'b0, 4'h0, 32'h0,        2'b01, 2'b00};
    tbl[8]  = '{1'b1, 1'b0, 32'h0,             1'b1, 1'b0, 1'b0, 4'h0, 32'h0,        2'b01, 2'b00};
    tbl[9]  = '{1'b1, 1'b1, hdr(8'h40, 16'd0), 1'b1, 1'b1, 1'b0, 4'h0, 32'h0,        2'b11, 2'b00};
    tbl[10] = '{1'b1, 1'b1, hdr(8'h01, 16'd0), 1'b1, 1'b0, 1'b0, 4'h0, 32'h0,        2'b11, 2'b00};
    tbl[11] = '{1'b1, 1'b1, hdr(8'h01, 16'd0), 1'b1, 1'b1, 1'b0, 4'h0, 32'h0,        2'b10, 2'b00};
    tbl[12] = '{1'b1, 1'b0, 32'h0,             1'b1, 1'b0, 1'b0, 4'h0, 32'h0,        2'b10, 2'b00};
    tbl[13] = '{1'b1, 1'b1, hdr(8'hC0, 16'd0), 1'b1, 1'b1, 1'b0, 4'h0, 32'h0,        2'b10, 2'b00};
    tbl[14] = '{1'b1, 1'b0, 32'h0,             1'b1, 1'b0, 1'b0, 4'h0, 32'h0,        2'b10, 2'b00};

    for (int i = 0; i < 15; i++) begin
      reset_n = tbl[i].rstn; v4 = tbl[i].vld; d4 = tbl[i].d;
      tick();
      chk($sformatf("t%0d sync_wait", i), 64'(s4), 64'(tbl[i].sync));
      chk($sformatf("t%0d packet_done", i), 64'(pd4), 64'(tbl[i].done));
      chk($sformatf("t%0d payload_vld", i), 64'(pv4), 64'(tbl[i].pvld));
      chk($sformatf("t%0d frame_active", i), 64'(fa4), 64'(tbl[i].fa));
      chk($sformatf("t%0d line_active", i), 64'(la4), 64'(tbl[i].la));
      chk($sformatf("t%0d hdr_err", i), 64'(he4), 64'(0));
      if (tbl[i].pvld) begin
        chk($sformatf("t%0d payload_be", i), 64'(be4), 64'(tbl[i].be));
        chk($sformatf("t%0d payload", i), 64'(pl4), 64'(tbl[i].pl));
        chk($sformatf("t%0d payload_vc", i), 64'(vc4), 64'(0));
        chk($sformatf("t%0d payload_dt", i), 64'(dt4), 64'(6'h2B));
      end
      if (i == 0) begin
        chk("reset payload_be", 64'(be4), 64'(0));
        chk("reset payload", 64'(pl4), 64'(0));
        chk("reset payload_dt", 64'(dt4), 64'(0));
      end
    end
    v4 = 1'b0;

    // Two-lane FS on VC0: two header beats, done right after the second.
    h = hdr(8'h00, 16'd0);
    v2 = 1'b1; d2 = h[15:0];  tick();
    chk("l2 fs beat1 sync_wait", 64'(s2), 64'(0));
    chk("l2 fs beat1 done", 64'(pd2), 64'(0));
    d2 = h[31:16]; tick();
    chk("l2 fs done", 64'(pd2), 64'(1));
    chk("l2 fs frame_active", 64'(fa2), 64'(2'b01));
    chk("l2 fs hdr_err", 64'(he2), 64'(0));
    chk("l2 fs sync_wait", 64'(s2), 64'(1));
    v2 = 1'b0; tick();
    chk("l2 fs done pulse width", 64'(pd2), 64'(0));

    // One-lane long packet with WC=0: 4 header beats + 2 CRC beats, no payload.
    h = hdr(8'h2A, 16'd0);
    cnt_pv = 0; early = 0;
    for (int b = 0; b < 4; b++) begin
      v1 = 1'b1; d1 = h[b*8 +: 8]; tick();
      if (pv1) cnt_pv++;
      if (pd1) early++;
    end
    chk("l1 wc0 line_active", 64'(la1), 64'(2'b01));
    d1 = 8'hA5; tick();
    if (pv1) cnt_pv++;
    if (pd1) early++;
    d1 = 8'h5A; tick();
    if (pv1) cnt_pv++;
    chk("l1 wc0 done", 64'(pd1), 64'(1));
    chk("l1 wc0 early done", 64'(early), 64'(0));
    v1 = 1'b0; tick();
    chk("l1 wc0 payload count", 64'(cnt_pv), 64'(0));
    chk("l1 wc0 line_active end", 64'(la1), 64'(2'b00));

    // Two-lane VC1 long packet, WC=4, three-cycle gap mid-body.
    h = hdr(8'h6B, 16'd4);
    v2 = 1'b1; d2 = h[15:0]; tick();
    d2 = h[31:16]; tick();
    chk("l2 vc1 line_active", 64'(la2), 64'(2'b10));
    chk("l2 vc1 sync_wait", 64'(s2), 64'(0));
    d2 = 16'hBBAA; tick();
    chk("l2 vc1 pvld1", 64'(pv2), 64'(1));
    chk("l2 vc1 payload1", 64'(pl2), 64'(16'hBBAA));
    chk("l2 vc1 be1", 64'(be2), 64'(2'b11));
    chk("l2 vc1 payload_vc", 64'(vc2), 64'(1));
    chk("l2 vc1 payload_dt", 64'(dt2), 64'(6'h2B));
    v2 = 1'b0; cnt_pv = 0; early = 0;
    for (int g = 0; g < 3; g++) begin
      tick();
      if (pv2) cnt_pv++;
      if (pd2) early++;
    end
    chk("l2 gap payload_vld", 64'(cnt_pv), 64'(0));
    chk("l2 gap done", 64'(early), 64'(0));
    chk("l2 gap line_active", 64'(la2), 64'(2'b10));
    v2 = 1'b1; d2 = 16'hDDCC; tick();
    chk("l2 vc1 pvld2", 64'(pv2), 64'(1));
    chk("l2 vc1 payload2", 64'(pl2), 64'(16'hDDCC));
    chk("l2 vc1 be2", 64'(be2), 64'(2'b11));
    chk("l2 vc1 line_active last", 64'(la2), 64'(2'b10));
    chk("l2 vc1 done early", 64'(pd2), 64'(0));
    d2 = 16'h1234; tick();
    chk("l2 vc1 crc done", 64'(pd2), 64'(1));
    chk("l2 vc1 crc pvld", 64'(pv2), 64'(0));
    chk("l2 vc1 line_active off", 64'(la2), 64'(2'b00));
    v2 = 1'b0; tick();

    // Same packet on untracked VC3: walked, no payload, done still pulses.
    h = hdr(8'hEB, 16'd4);
    cnt_pv = 0; early = 0;
    v2 = 1'b1; d2 = h[15:0]; tick();
    d2 = h[31:16]; tick();
    chk("l2 vc3 line_active", 64'(la2), 64'(2'b00));
    for (int b = 0; b < 3; b++) begin
      if (pd2) early++;
      d2 = 16'(16'h1111 * (b + 1)); tick();
      if (pv2) cnt_pv++;
    end
    chk("l2 vc3 done", 64'(pd2), 64'(1));
    chk("l2 vc3 early done", 64'(early), 64'(0));
    chk("l2 vc3 payload count", 64'(cnt_pv), 64'(0));
    chk("l2 vc3 frame_active", 64'(fa2), 64'(2'b01));
    v2 = 1'b0; tick();

    // enable low mid-body on the 2-lane instance, then a clean FS afterwards.
    h = hdr(8'h2B, 16'd8);
    v2 = 1'b1; d2 = h[15:0]; tick();
    d2 = h[31:16]; tick();
    d2 = 16'h7766; tick();
    enable = 1'b0; v2 = 1'b0; tick();
    chk("en low sync_wait", 64'(s2), 64'(1));
    chk("en low pvld", 64'(pv2), 64'(0));
    chk("en low line_active", 64'(la2), 64'(0));
    chk("en low frame_active", 64'(fa2), 64'(0));
    enable = 1'b1;
    h = hdr(8'h00, 16'd0);
    v2 = 1'b1; d2 = h[15:0]; tick();
    d2 = h[31:16]; tick();
    chk("en restart fs done", 64'(pd2), 64'(1));
    v2 = 1'b0; tick();

    // reset_n low mid-body on the 4-lane instance.
    v4 = 1'b1; d4 = hdr(8'h2B, 16'd8); tick();
    d4 = 32'hDEADBEEF; tick();
    chk("rst pre pvld", 64'(pv4), 64'(1));
    reset_n = 1'b0; v4 = 1'b0; tick();
    chk("rst mid sync_wait", 64'(s4), 64'(1));
    chk("rst mid outputs", 64'({pd4, pv4, be4, pl4, vc4, dt4, fa4, la4, he4}), 64'(0));
    reset_n = 1'b1; tick();

    // WC=0xFFFF: remain must not wrap; 16385 beats, last payload beat has 3 lanes.
    v4 = 1'b1; d4 = hdr(8'h2A, 16'hFFFF); tick();
    cnt_pv = 0; early = 0; last_be = 4'h0;
    for (int j = 0; j < 16385; j++) begin
      if (pd4) early++;
      d4 = 32'(j); tick();
      if (pv4) begin cnt_pv++; last_be = be4; end
    end
    chk("wcmax done", 64'(pd4), 64'(1));
    chk("wcmax early done", 64'(early), 64'(0));
    chk("wcmax payload beats", 64'(cnt_pv), 64'(16384));
    chk("wcmax last be", 64'(last_be), 64'(4'b0111));
    v4 = 1'b0; tick();

    // Header 00 00 00 01 on the 2-lane instance (frame_active is 00 after the reset).
    v2 = 1'b1; d2 = 16'h0000; tick();
    d2 = 16'h0100; tick();
    chk("ecc hdr done", 64'(pd2), 64'(1));
`ifdef CSI_ECC_CHECK_EN
    chk("ecc hdr_err", 64'(he2), 64'(1));
    chk("ecc frame_active", 64'(fa2), 64'(2'b00));
`else
    chk("ecc hdr_err", 64'(he2), 64'(0));
    chk("ecc frame_active", 64'(fa2), 64'(2'b01));
`endif
    v2 = 1'b0; tick();
    chk("ecc hdr_err pulse", 64'(he2), 64'(0));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
